fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction fetch stage.
// Owns the program counter and addresses the combinational instruction memory.
// Fetched words are captured with their PC into a 2-entry in-order buffer,
// which presents a valid/ready stream to decode.
// A redirect from execute flushes the buffer and restarts fetch at the target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    logic [31:0] pc;
    logic [31:0] buf_pc    [0:1];
    logic [31:0] buf_instr [0:1];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        fetch;
    logic [31:0] redirect_target;
    logic        unused_redirect_bits;

    // Low two bits of a redirect target are meaningless for word-aligned fetch.
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0);
    assign if_pc     = buf_pc[rd_ptr];
    assign if_instr  = buf_instr[rd_ptr];

    // A fetch can proceed when the buffer has room, or when a pop frees a slot in the same cycle.
    always_comb begin
        pop   = if_valid && if_ready;
        fetch = !redirect_valid && ((count < 2'd2) || pop);
    end

    // PC, buffer storage, pointers and occupancy; a redirect overrides any fetch or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]    <= 32'h0000_0000;
                buf_instr[i] <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            pc     <= redirect_target;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (fetch) begin
                buf_pc[wr_ptr]    <= pc;
                buf_instr[wr_ptr] <= imem_instr;
                wr_ptr            <= ~wr_ptr;
                pc                <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, fetch} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit with a scoreboard.
// Stimulus pushes the PCs it expects decode to receive; a monitor pops and
// compares on every completed valid/ready transfer.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    // Instruction memory contents: word index tagged with a fixed pattern.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a >> 2) ^ 32'hA500_0000;
    endfunction

    // Combinational instruction memory.
    always_comb imem_instr = memword(imem_addr);

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the redirect/ready inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        stepCycles(1);
    endtask

    task automatic doReset();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rst_n          = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every completed transfer must match the next expected PC.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_transfer actual_pc=%h required=none", if_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("stream_pc", if_pc, mon_exp);
                checkOutput("stream_instr", if_instr, memword(mon_exp));
            end
        end
    end

    initial begin
        rst_n          = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("reset_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("reset_imem_addr", imem_addr, 32'h0);
        checkOutput("reset_if_pc", if_pc, 32'h0);
        checkOutput("reset_if_instr", if_instr, 32'h0);

        // Full throughput from reset release.
        $display("[TB] throughput");
        if_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        @(negedge clk);
        rst_n = 1'b1;
        stepCycles(9);
        checkOutput("t1_drained", 32'(exp_q.size()), 32'h0);

        // Backpressure: buffer fills with PC 0 and 4, fetch holds at 8.
        $display("[TB] backpressure");
        doReset();
        stepCycles(3);
        checkOutput("bp_imem_addr_a", imem_addr, 32'h8);
        checkOutput("bp_if_pc_a", if_pc, 32'h0);
        stepCycles(2);
        checkOutput("bp_imem_addr_b", imem_addr, 32'h8);
        checkOutput("bp_if_valid", {31'h0, if_valid}, 32'h1);
        checkOutput("bp_if_pc_b", if_pc, 32'h0);
        checkOutput("bp_if_instr_b", if_instr, 32'hA500_0000);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        applyStimulus(1'b0, 32'h0, 1'b1);
        stepCycles(3);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Redirect to an unaligned target while the buffer is full.
        $display("[TB] redirect while full");
        applyStimulus(1'b1, 32'h0000_0102, 1'b0);
        checkOutput("rd_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("rd_imem_addr", imem_addr, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("rd_if_valid_next", {31'h0, if_valid}, 32'h1);
        checkOutput("rd_if_pc_next", if_pc, 32'h100);
        stepCycles(1);

        // Redirect coinciding with a pop, then a second redirect next cycle.
        $display("[TB] back-to-back redirect");
        applyStimulus(1'b1, 32'h0000_0200, 1'b1);
        applyStimulus(1'b1, 32'h0000_0300, 1'b1);
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        checkOutput("rr_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("rr_imem_addr", imem_addr, 32'h300);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        exp_q.push_back(32'h308);
        stepCycles(4);

        // PC wrap from the top of the address space.
        $display("[TB] pc wrap");
        exp_q.push_back(32'h30C);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_imem_addr", imem_addr, 32'h0);
        stepCycles(3);
        applyStimulus(1'b0, 32'h0, 1'b0);
        stepCycles(1);
        checkOutput("full_imem_addr", imem_addr, 32'h10);
        checkOutput("full_if_pc", if_pc, 32'h8);

        // Asynchronous reset mid-cycle with the buffer full.
        $display("[TB] async reset");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("areset_imem_addr", imem_addr, 32'h0);
        checkOutput("areset_if_pc", if_pc, 32'h0);
        checkOutput("areset_if_instr", if_instr, 32'h0);
        #10;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
